// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks LENGTH consecutive RAM words from BASE_ADDR on
// the read port and streams them out over valid/ready. A small FIFO of
// depth RD_LAT+2 absorbs the RAM read latency and downstream stalls. Reads
// are only issued when the FIFO is guaranteed to have room for the data.
module ram_stream_reader #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [addr_width-1:0] BASE_ADDR,
  input  logic [addr_width:0]   LENGTH,
  output logic [addr_width-1:0] ADRR_R,
  input  logic [data_width-1:0] Q_R,
  output logic [data_width-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int DEPTH = RD_LAT + 2;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for occupancy plus every in-flight read plus one more.
  localparam int CW    = $clog2(DEPTH + RD_LAT + 2) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t                state_reg;
  logic [addr_width-1:0] addr_reg;        // address currently on the RAM port
  logic [addr_width-1:0] next_addr_reg;   // address of the next read to issue
  logic [addr_width:0]   remain_reg;      // reads still to be issued
  logic                  busy_reg;
  logic                  done_reg;

  // Bit i set: a read issued i cycles ago; bit RD_LAT marks data on Q_R now.
  logic [RD_LAT:0]       flag_reg;
  logic [RD_LAT:0]       flag_next;

  logic [data_width-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         occ_reg;

  logic [CW-1:0]         inflight;
  logic                  push;
  logic                  pop;
  logic                  issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads that have been issued but whose data is not yet in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight = inflight + CW'(flag_reg[i]);
    end
  end

  assign push = flag_reg[RD_LAT];
  assign pop  = (occ_reg != '0) && OUT_READY;

  // A new read is allowed only if every word already owed to the FIFO,
  // plus this one, still fits after this cycle's pop.
  assign issue = (state_reg == RUN) && (remain_reg != '0) &&
                 ((occ_reg + inflight - CW'(pop)) < CW'(DEPTH));

  assign flag_next[0] = issue;
  for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_flag
    assign flag_next[gi] = flag_reg[gi-1];
  end

  // FIFO storage: capture Q_R when the matching issue flag reaches the end.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr_reg] <= Q_R;
    end
  end

  // Sequencer FSM, address generator, in-flight tracking and FIFO pointers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      next_addr_reg <= '0;
      remain_reg    <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      flag_reg      <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      occ_reg       <= '0;
    end else begin
      flag_reg <= flag_next;
      occ_reg  <= occ_reg + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (issue) begin
        addr_reg      <= next_addr_reg;
        next_addr_reg <= next_addr_reg + 1'b1;
        remain_reg    <= remain_reg - 1'b1;
      end

      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            next_addr_reg <= BASE_ADDR;
            remain_reg    <= LENGTH;
            busy_reg      <= 1'b1;
            if (LENGTH == '0) begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && (remain_reg == (addr_width + 1)'(1))) begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ_reg == '0) && (inflight == '0)) begin
            state_reg <= FINISH;
            done_reg  <= 1'b1;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ADRR_R    = addr_reg;
  assign OUT_DATA  = fifo_mem[rd_ptr_reg];
  assign OUT_VALID = (occ_reg != '0);
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: drives two readers in lockstep, one with a
// combinational RAM (RD_LAT=0) and one with a registered RAM (RD_LAT=1).
// Expected words are queued when a burst is started; a monitor pops and
// compares on every accepted transfer.
module tb_ram_stream_reader;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [9:0]       base_addr;
  logic [10:0]      length;
  logic             out_ready;
  logic [1:0][9:0]  adrr_r;
  logic [1:0][31:0] out_data;
  logic [1:0]       out_valid;
  logic [1:0]       busy;
  logic [1:0]       done;

  logic [31:0] ram_mem [1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;

  logic [31:0] exp_q [2][$];
  logic [1:0]  first_seen;
  logic [1:0]  done_seen;
  int          first_cyc [2];
  int          done_cyc [2];
  int          xfer_cnt [2];
  logic [1:0]  prev_stall;
  logic [31:0] prev_data [2];

  logic        ready_toggle = 1'b0;
  logic [5:0]  rpat = 6'b101001;   // LSB first: 1,0,0,1,0,1
  int          pidx = 0;

  logic [31:0] ev [8];
  logic [9:0]  ea [4];
  logic [9:0]  old_addr [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [31:0] q_r;
    if (gi == 0) begin : g_comb
      assign q_r = ram_mem[adrr_r[gi]];
    end else begin : g_regd
      always @(posedge clk) q_r <= ram_mem[adrr_r[gi]];
    end

    ram_stream_reader #(
      .addr_width(10),
      .data_width(32),
      .RD_LAT    (gi)
    ) u_dut (
      .CLK      (clk),
      .RESET_N  (rst_n),
      .START    (start),
      .BASE_ADDR(base_addr),
      .LENGTH   (length),
      .ADRR_R   (adrr_r[gi]),
      .Q_R      (q_r),
      .OUT_DATA (out_data[gi]),
      .OUT_VALID(out_valid[gi]),
      .OUT_READY(out_ready),
      .BUSY     (busy[gi]),
      .DONE     (done[gi])
    );
  end

  // Ready driver: constant high or the repeating stall pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) begin
        out_ready = rpat[pidx];
        pidx = (pidx == 5) ? 0 : pidx + 1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, latency and DONE capture.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = '0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (prev_stall[g]) begin
          checks++;
          if (!out_valid[g] || out_data[g] !== prev_data[g]) begin
            errors++;
            $display("FAIL stall_hold dut%0d got v=%0b d=%h want v=1 d=%h",
                     g, out_valid[g], out_data[g], prev_data[g]);
          end
        end
        if (out_valid[g] && !first_seen[g]) begin
          first_seen[g] = 1'b1;
          first_cyc[g]  = cyc;
        end
        if (done[g]) begin
          done_seen[g] = 1'b1;
          done_cyc[g]  = cyc;
        end
        if (out_valid[g] && out_ready) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_word dut%0d got %h want none", g, out_data[g]);
          end else begin
            logic [31:0] w;
            w = exp_q[g].pop_front();
            if (out_data[g] !== w) begin
              errors++;
              $display("FAIL data dut%0d got %h want %h", g, out_data[g], w);
            end
          end
          xfer_cnt[g]++;
        end
        prev_stall[g] = out_valid[g] && !out_ready;
        prev_data[g]  = out_data[g];
      end
    end
  end

  task automatic check(input string name, input int g,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, g, got, want);
    end
  endtask

  // Queue the n words in ev for both readers, then pulse START for one edge.
  task automatic run_burst(input logic [9:0] base, input logic [10:0] len, input int n);
    for (int g = 0; g < 2; g++) begin
      done_seen[g]  = 1'b0;
      first_seen[g] = 1'b0;
      xfer_cnt[g]   = 0;
      for (int i = 0; i < n; i++) exp_q[g].push_back(ev[i]);
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    length    = len;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    $display("burst base=%h len=%0d started at cycle %0d", base, len, start_cyc);
  endtask

  task automatic wait_done(input int n, input bit chk_first, input bit chk_done);
    int t;
    t = 0;
    while (!(done_seen[0] && done_seen[1]) && t < 400) begin
      @(negedge clk);
      t++;
    end
    for (int g = 0; g < 2; g++) begin
      check("done_seen", g, 32'(done_seen[g]), 32'd1);
      check("drained", g, 32'(exp_q[g].size()), 32'd0);
      if (chk_first) check("first_latency", g, 32'(first_cyc[g] - start_cyc), 32'(g + 2));
      if (chk_done)  check("done_latency", g, 32'(done_cyc[g] - start_cyc), 32'(n + g + 3));
    end
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("idle_busy", g, 32'(busy[g]), 32'd0);
      check("idle_done", g, 32'(done[g]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    first_seen = '0;
    done_seen  = '0;
    prev_stall = '0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0000_00A0 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_adrr", g, 32'(adrr_r[g]), 32'h0);
      check("rst_data", g, out_data[g], 32'h0);
      check("rst_valid", g, 32'(out_valid[g]), 32'd0);
      check("rst_busy", g, 32'(busy[g]), 32'd0);
      check("rst_done", g, 32'(done[g]), 32'd0);
    end

    // Case 1: BASE=2 LEN=4, ready high
    ev = '{32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(10'h002, 11'd4, 4);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("busy_after_start", g, 32'(busy[g]), 32'd1);
    wait_done(4, 1'b1, 1'b1);

    // Case 2: address wrap 0x3FE..0x001
    ev = '{32'h49E, 32'h49F, 32'hA0, 32'hA1, 32'h0, 32'h0, 32'h0, 32'h0};
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    run_burst(10'h3FE, 11'd4, 4);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) check("wrap_adrr", g, 32'(adrr_r[g]), 32'(ea[j]));
    end
    wait_done(4, 1'b1, 1'b1);

    // Case 3: LEN=6 with ready pattern 1,0,0,1,0,1
    ev = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'h0, 32'h0};
    @(posedge clk);
    #1;
    pidx = 0;
    ready_toggle = 1'b1;
    run_burst(10'h001, 11'd6, 6);
    wait_done(6, 1'b1, 1'b0);
    ready_toggle = 1'b0;
    @(negedge clk);

    // Case 4: LEN=0
    for (int g = 0; g < 2; g++) old_addr[g] = adrr_r[g];
    run_burst(10'h155, 11'd0, 0);
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("len0_done", g, 32'(done[g]), 32'd1);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("len0_done_pulse", g, 32'(done[g]), 32'd0);
      check("len0_busy", g, 32'(busy[g]), 32'd0);
      check("len0_adrr", g, 32'(adrr_r[g]), 32'(old_addr[g]));
      check("len0_valid", g, 32'(out_valid[g]), 32'd0);
    end

    // Case 5: second START mid-burst is ignored
    ev = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0, 32'h0, 32'h0};
    run_burst(10'h000, 11'd5, 5);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 10'h100;
    length    = 11'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, 1'b1, 1'b1);

    // Case 6: reset after 3 of 8 words, then a clean burst
    ev = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7};
    run_burst(10'h000, 11'd8, 8);
    begin
      int t;
      t = 0;
      while (xfer_cnt[1] < 3 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("pre_reset_words", 1, 32'(xfer_cnt[1] >= 3), 32'd1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      exp_q[g].delete();
      done_seen[g] = 1'b0;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("abort_valid", g, 32'(out_valid[g]), 32'd0);
      check("abort_busy", g, 32'(busy[g]), 32'd0);
      check("abort_adrr", g, 32'(adrr_r[g]), 32'h0);
    end
    repeat (12) @(negedge clk);
    for (int g = 0; g < 2; g++) check("abort_no_done", g, 32'(done_seen[g]), 32'd0);

    ev = '{32'hA4, 32'hA5, 32'hA6, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(10'h004, 11'd3, 3);
    wait_done(3, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
